// File: rtl/mips_defs.sv
// Shared MIPS pipeline encodings for the fetch/redirect path.
package mips_defs;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BGEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLEZ = 3'd5,
    BR_BLTZ = 3'd6
  } br_op_e;

  typedef enum logic [1:0] {
    JMP_NONE = 2'd0,
    JMP_IMM  = 2'd1,
    JMP_REG  = 2'd2
  } jmp_op_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/pc_redirect_br_cond.sv
// Branch condition evaluation from comparator result and rs sign/zero tests.
module br_cond
  import mips_defs::*;
(
  input  logic [2:0]  br_op,
  input  logic        cmp_eq,
  input  logic [31:0] rs_val,
  output logic        cond
);

  logic rs_neg;
  logic rs_zero;

  always_comb begin
    rs_neg  = rs_val[31];
    rs_zero = (rs_val == '0);
    cond    = 1'b0;
    case (br_op)
      BR_BEQ:  cond = cmp_eq;
      BR_BNE:  cond = !cmp_eq;
      BR_BGEZ: cond = !rs_neg;
      BR_BGTZ: cond = !rs_neg && !rs_zero;
      BR_BLEZ: cond = rs_neg || rs_zero;
      BR_BLTZ: cond = rs_neg;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_redirect.sv
// IF program counter with delayed-branch redirect from ID and branch statistics.
module pc_redirect
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             id_valid,
  input  logic [31:0]      id_pc,
  input  logic [2:0]       br_op,
  input  logic [1:0]       jmp_op,
  input  logic             cmp_eq,
  input  logic [31:0]      rs_val,
  input  logic [15:0]      imm16,
  input  logic [25:0]      idx26,
  output logic [31:0]      pc_if,
  output logic [31:0]      link_addr,
  output logic             br_taken,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] br_taken_cnt
);

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] br_taken_cnt_q, br_taken_cnt_d;

  logic        cond;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] jmp_target;
  logic        is_branch;
  logic        is_jreg;
  logic        is_jimm;

  br_cond u_br_cond (
    .br_op  (br_op),
    .cmp_eq (cmp_eq),
    .rs_val (rs_val),
    .cond   (cond)
  );

  always_comb begin
    pc_plus4   = id_pc + 32'd4;
    br_target  = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
    jmp_target = {pc_plus4[31:28], idx26, 2'b00};
    link_addr  = id_pc + 32'd8;
    br_taken   = id_valid && cond;
    is_jreg    = id_valid && (jmp_op == JMP_REG);
    is_jimm    = id_valid && (jmp_op == JMP_IMM);
    // Only a lone branch counts; a branch paired with any jump code is ignored.
    is_branch  = id_valid && (jmp_op == JMP_NONE) &&
                 (br_op >= BR_BEQ) && (br_op <= BR_BLTZ);

    pc_d           = pc_q;
    br_cnt_d       = br_cnt_q;
    br_taken_cnt_d = br_taken_cnt_q;

    if (!stall) begin
      if (is_jreg)       pc_d = rs_val;
      else if (is_jimm)  pc_d = jmp_target;
      else if (br_taken) pc_d = br_target;
      else               pc_d = pc_q + 32'd4;

      if (is_branch) begin
        br_cnt_d = br_cnt_q + CNT_W'(1);
        if (br_taken) br_taken_cnt_d = br_taken_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q           <= RESET_PC;
      br_cnt_q       <= '0;
      br_taken_cnt_q <= '0;
    end else begin
      pc_q           <= pc_d;
      br_cnt_q       <= br_cnt_d;
      br_taken_cnt_q <= br_taken_cnt_d;
    end
  end

  assign pc_if        = pc_q;
  assign br_cnt       = br_cnt_q;
  assign br_taken_cnt = br_taken_cnt_q;

endmodule
